// File: rtl/stride_cnt_pkg.sv
// Shared types for the stride counter slice: FSM state encoding and run modes.
package stride_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_WRAP    = 1'b1;

endpackage

// File: rtl/stride_cnt_if.sv
// Config/control inputs plus the count stream handshake between a host/consumer and the controller.
interface stride_cnt_if #(
    parameter int WIDTH = 8
);
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_start;
    logic [WIDTH-1:0] cfg_stride;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_mode;
    logic             go;
    logic             halt;
    logic             cnt_valid;
    logic             cnt_ready;
    logic [WIDTH-1:0] cnt_o;
    logic             busy;
    logic             done;

    // Host/consumer side: programs the counter and accepts counts.
    modport master (
        output cfg_we, cfg_start, cfg_stride, cfg_limit, cfg_mode, go, halt, cnt_ready,
        input  cnt_valid, cnt_o, busy, done
    );

    // Controller side.
    modport slave (
        input  cfg_we, cfg_start, cfg_stride, cfg_limit, cfg_mode, go, halt, cnt_ready,
        output cnt_valid, cnt_o, busy, done
    );
endinterface

// File: rtl/stride_cnt_dp.sv
// Stride counter datapath: count register, WIDTH+1 bit adder and limit compare.
// The extra adder bit means a step that overflows WIDTH bits still reads as over the limit.
module stride_cnt_dp #(
    parameter int WIDTH     = 8,
    parameter int RST_START = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             wrap,
    input  logic [WIDTH-1:0] start,
    input  logic [WIDTH-1:0] stride,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt_o,
    output logic             over_limit
);

    logic [WIDTH:0] nxt;

    assign nxt        = {1'b0, cnt_o} + {1'b0, stride};
    assign over_limit = (nxt > {1'b0, limit});

    // Count register: load/wrap restart from start, step advances by the stride, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_o <= WIDTH'(RST_START);
        end else if (load || wrap) begin
            cnt_o <= start;
        end else if (step) begin
            cnt_o <= nxt[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/stride_cnt_ctrl.sv
// Stride counter controller: FSM, config registers, count stream handshake.
// Reset defaults plus go give the free-running odd counter 1,3,5,...,255,1,...
// Optional feature macro: STRIDE_CNT_WRAPS_EN adds the saturating 16-bit wrap_cnt output.
module stride_cnt_ctrl
    import stride_cnt_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int RST_START  = 1,
    parameter int RST_STRIDE = 2
) (
    input logic       clk,
    input logic       reset,
    stride_cnt_if.slave bus
`ifdef STRIDE_CNT_WRAPS_EN
    ,
    output logic [15:0] wrap_cnt
`endif
);

    state_t           state;
    logic             cnt_valid_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] stride_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic [WIDTH-1:0] cnt;
    logic             over_limit;

    logic             cfg_open;
    logic             take_cfg;
    logic [WIDTH-1:0] eff_start;
    logic [WIDTH-1:0] eff_stride;
    logic [WIDTH-1:0] eff_limit;
    logic             start_ok;
    logic             go_ok;
    logic             beat;
    logic             load;
    logic             step;
    logic             wrap;

    // Config is only writable outside a run; a write in the go cycle is seen by that go.
    assign cfg_open   = (state != RUN);
    assign take_cfg   = bus.cfg_we && cfg_open;
    assign eff_start  = take_cfg ? bus.cfg_start  : start_q;
    assign eff_stride = take_cfg ? bus.cfg_stride : stride_q;
    assign eff_limit  = take_cfg ? bus.cfg_limit  : limit_q;
    assign start_ok   = (eff_start <= eff_limit);

    assign go_ok = cfg_open && bus.go && !bus.halt;
    assign beat  = (state == RUN) && cnt_valid_q && bus.cnt_ready;
    assign load  = go_ok && start_ok;
    assign step  = beat && !over_limit;
    assign wrap  = beat && over_limit && (mode_q == MODE_WRAP);

    assign bus.cnt_valid = cnt_valid_q;
    assign bus.cnt_o     = cnt;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Config registers, reset to the free-running odd counter setup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= WIDTH'(RST_START);
            stride_q <= WIDTH'(RST_STRIDE);
            limit_q  <= '1;
            mode_q   <= MODE_WRAP;
        end else if (take_cfg) begin
            start_q  <= bus.cfg_start;
            stride_q <= bus.cfg_stride;
            limit_q  <= bus.cfg_limit;
            mode_q   <= bus.cfg_mode;
        end
    end

    // Run FSM with registered valid/busy/done; halt wins over go, go is ignored during a run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.halt) begin
                        state       <= IDLE;
                        cnt_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b0;
                    end else if (bus.go) begin
                        if (start_ok) begin
                            state       <= RUN;
                            cnt_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                        end else begin
                            state       <= DONE;
                            cnt_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.halt) begin
                        state       <= IDLE;
                        cnt_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b0;
                    end else if (beat && over_limit && (mode_q == MODE_ONESHOT)) begin
                        state       <= DONE;
                        cnt_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    stride_cnt_dp #(
        .WIDTH     (WIDTH),
        .RST_START (RST_START)
    ) u_dp (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .wrap       (wrap),
        .start      (eff_start),
        .stride     (eff_stride),
        .limit      (eff_limit),
        .cnt_o      (cnt),
        .over_limit (over_limit)
    );

`ifdef STRIDE_CNT_WRAPS_EN
    // Wrap counter: cleared by an accepted go, saturates instead of rolling over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_cnt <= 16'h0000;
        end else if (go_ok) begin
            wrap_cnt <= 16'h0000;
        end else if (wrap && (wrap_cnt != 16'hFFFF)) begin
            wrap_cnt <= wrap_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_stride_cnt_ctrl.sv
// Testbench for stride_cnt_ctrl: directed sequences, a vector table and a randomized
// phase checked against a behavioural model of the counter rules.
module tb_stride_cnt_ctrl;

    logic clk;
    logic reset;
`ifdef STRIDE_CNT_WRAPS_EN
    logic [15:0] wrap_cnt;
`endif

    stride_cnt_if #(.WIDTH(8)) bus ();

    stride_cnt_ctrl #(
        .WIDTH      (8),
        .RST_START  (1),
        .RST_STRIDE (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef STRIDE_CNT_WRAPS_EN
        ,
        .wrap_cnt (wrap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int num_compared   = 0;
    int num_mismatched = 0;

    // Behavioural model state
    int m_start, m_stride, m_limit, m_mode;
    int m_cur, m_wraps;
    bit m_running, m_finished;

    typedef struct {
        logic       we;
        logic [7:0] start;
        logic [7:0] stride;
        logic [7:0] limit;
        logic       mode;
        logic       go;
        logic       halt;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_cnt;
        logic       chk_cnt;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mkVec(int we, int st, int sd, int lm, int md, int go, int ht, int rd,
                                   int ev, int ec, int cc, int eb, int ed);
        vec_t v;
        v.we = we[0]; v.start = st[7:0]; v.stride = sd[7:0]; v.limit = lm[7:0];
        v.mode = md[0]; v.go = go[0]; v.halt = ht[0]; v.ready = rd[0];
        v.exp_valid = ev[0]; v.exp_cnt = ec[7:0]; v.chk_cnt = cc[0];
        v.exp_busy = eb[0]; v.exp_done = ed[0];
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_compared++;
        if (act !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_start = 1; m_stride = 2; m_limit = 255; m_mode = 1;
        m_cur = 1; m_wraps = 0; m_running = 0; m_finished = 0;
    endtask

    task automatic modelStep(input int we, input int st, input int sd, input int lm, input int md,
                             input int go, input int ht, input int rd);
        int nxt;
        if (!m_running && we != 0) begin
            m_start = st; m_stride = sd; m_limit = lm; m_mode = md;
        end
        if (m_running) begin
            if (rd != 0) begin
                nxt = m_cur + m_stride;
                if (nxt <= m_limit) begin
                    m_cur = nxt;
                end else if (m_mode != 0) begin
                    m_cur = m_start;
                    if (m_wraps < 65535) m_wraps++;
                end else begin
                    m_running = 0; m_finished = 1;
                end
            end
            if (ht != 0) begin
                m_running = 0; m_finished = 0;
            end
        end else if (ht != 0) begin
            m_finished = 0;
        end else if (go != 0) begin
            m_wraps = 0;
            if (m_start <= m_limit) begin
                m_running = 1; m_finished = 0; m_cur = m_start;
            end else begin
                m_finished = 1;
            end
        end
    endtask

    task automatic applyStimulus(input int we, input int st, input int sd, input int lm, input int md,
                                 input int go, input int ht, input int rd);
        bus.cfg_we     = we[0];
        bus.cfg_start  = st[7:0];
        bus.cfg_stride = sd[7:0];
        bus.cfg_limit  = lm[7:0];
        bus.cfg_mode   = md[0];
        bus.go         = go[0];
        bus.halt       = ht[0];
        bus.cnt_ready  = rd[0];
        modelStep(we, st, sd, lm, md, go, ht, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int ev, input int ec, input int cc,
                               input int eb, input int ed);
        compare({name, ".valid"}, 32'(bus.cnt_valid), ev);
        if (cc != 0) compare({name, ".cnt"}, 32'(bus.cnt_o), ec);
        compare({name, ".busy"}, 32'(bus.busy), eb);
        compare({name, ".done"}, 32'(bus.done), ed);
    endtask

    task automatic checkModel(input string name);
        compare({name, ".valid"}, 32'(bus.cnt_valid), 32'(m_running));
        compare({name, ".busy"}, 32'(bus.busy), 32'(m_running));
        compare({name, ".done"}, 32'(bus.done), 32'(m_finished));
        if (m_running) compare({name, ".cnt"}, 32'(bus.cnt_o), m_cur);
`ifdef STRIDE_CNT_WRAPS_EN
        compare({name, ".wrap_cnt"}, 32'(wrap_cnt), m_wraps);
`endif
    endtask

    task automatic doReset();
        bus.cfg_we = 0; bus.cfg_start = 0; bus.cfg_stride = 0; bus.cfg_limit = 0;
        bus.cfg_mode = 0; bus.go = 0; bus.halt = 0; bus.cnt_ready = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        int exp_cnt;
        vecs[0]  = mkVec(1, 1, 2, 9, 0, 1, 0, 0,   1, 1, 1, 1, 0);
        vecs[1]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 3, 1, 1, 0);
        vecs[2]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 5, 1, 1, 0);
        vecs[3]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0,   1, 5, 1, 1, 0);
        vecs[4]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0,   1, 5, 1, 1, 0);
        vecs[5]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0,   1, 5, 1, 1, 0);
        vecs[6]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 7, 1, 1, 0);
        vecs[7]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 9, 1, 1, 0);
        vecs[8]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   0, 9, 1, 0, 1);
        vecs[9]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0,   0, 9, 1, 0, 1);
        vecs[10] = mkVec(0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 1, 1, 0);
        vecs[11] = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 3, 1, 1, 0);
        vecs[12] = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 5, 1, 1, 0);
        vecs[13] = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 7, 1, 1, 0);
        vecs[14] = mkVec(1, 50, 7, 200, 1, 0, 0, 0, 1, 7, 1, 1, 0);
        vecs[15] = mkVec(0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0);
        vecs[16] = mkVec(0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 1, 1, 0);
        vecs[17] = mkVec(0, 0, 0, 0, 0, 1, 0, 1,   1, 3, 1, 1, 0);
        vecs[18] = mkVec(0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0);
        vecs[19] = mkVec(1, 20, 2, 10, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        vecs[20] = mkVec(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
        vecs[21] = mkVec(1, 4, 0, 10, 0, 1, 0, 0,  1, 4, 1, 1, 0);
        vecs[22] = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 4, 1, 1, 0);
        vecs[23] = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 4, 1, 1, 0);
        vecs[24] = mkVec(0, 0, 0, 0, 0, 0, 0, 1,   1, 4, 1, 1, 0);
        vecs[25] = mkVec(0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0);

        $display("[TB] reset state");
        doReset();
        checkOutput("reset", 0, 1, 1, 0, 0);
`ifdef STRIDE_CNT_WRAPS_EN
        compare("reset.wrap_cnt", 32'(wrap_cnt), 0);
`endif

        $display("[TB] free-running odd counter from reset defaults");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        checkOutput("odd.first", 1, 1, 1, 1, 0);
        for (int k = 1; k <= 130; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
            exp_cnt = (1 + 2 * k) % 256;
            checkOutput($sformatf("odd.beat%0d", k), 1, exp_cnt, 1, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("odd.halt", 0, 0, 0, 0, 0);

        $display("[TB] vector table");
        for (int i = 0; i < 26; i++) begin
            applyStimulus(int'(vecs[i].we), int'(vecs[i].start), int'(vecs[i].stride),
                          int'(vecs[i].limit), int'(vecs[i].mode), int'(vecs[i].go),
                          int'(vecs[i].halt), int'(vecs[i].ready));
            checkOutput($sformatf("vec%0d", i), int'(vecs[i].exp_valid), int'(vecs[i].exp_cnt),
                        int'(vecs[i].chk_cnt), int'(vecs[i].exp_busy), int'(vecs[i].exp_done));
        end

        $display("[TB] reset mid-run restores config");
        applyStimulus(1, 10, 3, 100, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("midrst.pre", 1, 16, 1, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst.async", 0, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        checkOutput("midrst.go", 1, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("midrst.step", 1, 3, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

`ifdef STRIDE_CNT_WRAPS_EN
        $display("[TB] wrap counter");
        doReset();
        applyStimulus(1, 0, 64, 255, 1, 1, 0, 1);
        for (int j = 1; j <= 12; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
            checkOutput($sformatf("wrap.beat%0d", j), 1, (64 * j) % 256, 1, 1, 0);
        end
        compare("wrap.count12", 32'(wrap_cnt), 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        compare("wrap.clear_on_go", 32'(wrap_cnt), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
`endif

        $display("[TB] randomized run against model");
        for (int i = 0; i < 800; i++) begin
            int we, st, sd, lm, md, go, ht, rd;
            we = ($urandom_range(0, 7) == 0) ? 1 : 0;
            st = int'($urandom_range(0, 63));
            sd = int'($urandom_range(0, 40));
            lm = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(100, 255));
            md = int'($urandom_range(0, 1));
            go = ($urandom_range(0, 5) == 0) ? 1 : 0;
            ht = ($urandom_range(0, 29) == 0) ? 1 : 0;
            rd = ($urandom_range(0, 9) < 7) ? 1 : 0;
            applyStimulus(we, st, sd, lm, md, go, ht, rd);
            checkModel($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
